// File: rtl/updn_mod_counter.sv
// updn_mod_counter: up/down counter with runtime lower/upper limits,
// wrap or saturate at the limits, synchronous load, clock enable,
// a registered terminal-count pulse and a saturating boundary-event counter.
module updn_mod_counter #(
   parameter int unsigned WIDTH     = 5,
   parameter int unsigned EVT_W     = 4,
   parameter int unsigned RESET_VAL = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             mode,
   input  logic             sat,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] lo,
   input  logic [WIDTH-1:0] hi,
   input  logic             evt_clr,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic [EVT_W-1:0] evt_cnt,
   output logic             at_lo,
   output logic             at_hi,
   output logic             cfg_err
);

   localparam logic [WIDTH-1:0] RST_Q   = RESET_VAL[WIDTH-1:0];
   localparam logic [EVT_W-1:0] EVT_MAX = '1;

   logic [WIDTH-1:0] load_clamped;
   logic [WIDTH-1:0] q_nxt;
   logic             evt;

   // Status flags are taken straight from the live count and limits.
   assign at_lo   = (q == lo);
   assign at_hi   = (q == hi);
   assign cfg_err = (lo > hi);

   // Clamp the load value into [lo,hi]; only meaningful when the limits are sane.
   always_comb begin
      load_clamped = load_val;
      if (load_val < lo) begin
         load_clamped = lo;
      end else if (load_val > hi) begin
         load_clamped = hi;
      end
   end

   // Next count and boundary-event detection; load beats the cfg_err hold, which beats en.
   always_comb begin
      q_nxt = q;
      evt   = 1'b0;
      if (load) begin
         q_nxt = cfg_err ? load_val : load_clamped;
      end else if (!cfg_err && en) begin
         if (!mode) begin
            // q >= hi also covers a count left above hi by a limit change
            if (q < hi) begin
               q_nxt = q + 1'b1;
            end else begin
               evt   = 1'b1;
               q_nxt = sat ? hi : lo;
            end
         end else begin
            if (q > lo) begin
               q_nxt = q - 1'b1;
            end else begin
               evt   = 1'b1;
               q_nxt = sat ? lo : hi;
            end
         end
      end
   end

   // Count register and terminal-count pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q  <= RST_Q;
         tc <= 1'b0;
      end else begin
         q  <= q_nxt;
         tc <= evt;
      end
   end

   // Boundary-event counter: saturates at all-ones, clear wins over a coincident event.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         evt_cnt <= '0;
      end else if (evt_clr) begin
         evt_cnt <= '0;
      end else if (evt && (evt_cnt != EVT_MAX)) begin
         evt_cnt <= evt_cnt + 1'b1;
      end
   end

endmodule

// File: doc/updn_mod_counter.md
# updn_mod_counter

Parametrised up/down counter with runtime-programmable lower/upper limits, wrap or saturate selection, synchronous load and clock enable. It adds a registered terminal-count pulse and a saturating boundary-event counter. It is the general-purpose successor to the fixed 5-bit up/down counter and serves as the timebase/index generator for sequencing logic in the same clock domain.

## Interface
- WIDTH, 5, counter width in bits (2..16)
- EVT_W, 4, width of boundary-event counter (1..16)
- RESET_VAL, 0, value of q after reset (must fit WIDTH)

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- en  in  1  count enable; step taken only when 1
- mode  in  1  0 = count up, 1 = count down
- sat  in  1  0 = wrap at limits, 1 = saturate at limits
- load  in  1  synchronous load strobe (priority over en)
- load_val  in  WIDTH  value for load
- lo  in  WIDTH  lower limit (unsigned, inclusive)
- hi  in  WIDTH  upper limit (unsigned, inclusive)
- evt_clr  in  1  synchronous clear of evt_cnt
- q  out  WIDTH  counter value (registered)
- tc  out  1  registered one-cycle boundary-event pulse
- evt_cnt  out  EVT_W  saturating count of boundary events (registered)
- at_lo  out  1  combinational: q == lo
- at_hi  out  1  combinational: q == hi
- cfg_err  out  1  combinational: lo > hi

One clock; reset is asynchronous and active-low.

## Operation
- Reset (reset=0, async): q=RESET_VAL, tc=0, evt_cnt=0; takes effect immediately, independent of clk; mid-count reset abandons count.
- Priority per rising edge: load > (cfg_err hold) > en step > hold.
- load=1: q <= clamp(load_val) to [lo,hi] when cfg_err=0; q <= load_val verbatim when cfg_err=1. No event, tc=0.
- cfg_err=1 and load=0: q holds regardless of en; tc=0; no event.
- en=0: q holds, tc=0.
- Up step (mode=0, en=1): if q < hi, q <= q+1. If q >= hi (includes q > hi after limit change): boundary event; sat=0 -> q <= lo; sat=1 -> q <= hi.
- Down step (mode=1): if q > lo, q <= q-1. If q <= lo: boundary event; sat=0 -> q <= hi; sat=1 -> q <= lo.
- lo == hi: every enabled step is a boundary event; q = lo.
- Arithmetic unsigned, WIDTH bits; no intermediate overflow possible (increment only below hi, decrement only above lo).
- Boundary event: tc <= 1 for the following cycle, else tc <= 0. Saturate mode still pulses tc on every attempted step past the limit.
- evt_cnt: +1 per event, saturates at 2^EVT_W-1. evt_clr=1 -> evt_cnt <= 0, beats a simultaneous event (event not counted); q/tc unaffected by evt_clr.
- Limits/mode/sat sampled each edge; changes take effect on the next edge; no internal latching.

## Timing
- q, tc, evt_cnt update on the rising clk edge; latency 1 cycle from en/load/evt_clr.
- tc high exactly the cycle after the edge causing the event; back-to-back events keep tc high continuously.
- at_lo, at_hi, cfg_err are combinational from current q, lo, hi (no register delay).
- Reset release: first step on the first rising edge with reset=1.

## Test plan
- Reset: WIDTH=5, RESET_VAL=0, assert reset mid-count (q=9) -> q=0, tc=0, evt_cnt=0 immediately, before next edge.
- Up wrap: lo=3, hi=7, sat=0, mode=0, en=1 from q=3 -> q 4,5,6,7,3; tc=1 only in cycle q=3 after wrap; evt_cnt=1.
- Down saturate: lo=2, hi=10, sat=1, mode=1 from q=4 -> 3,2,2,2; tc=1 for each of the two cycles after clamped steps; evt_cnt=2.
- Load/clamp: lo=5, hi=20, load_val=31 with en=1 -> q=20, tc=0; load_val=1 -> q=5; cfg_err (lo=9, hi=4) with load_val=31 -> q=31, then en=1 steps hold q=31.
- Limit change: q=20, set hi=12, mode=0, sat=0 -> next edge q=lo, tc=1; mode=1 with q < lo -> q=hi via event.
- evt_cnt: EVT_W=2, force 5 consecutive events with lo==hi -> evt_cnt 1,2,3,3,3; evt_clr coinciding with an event -> evt_cnt=0.
